// File: rtl/l2_dual_port_arbiter.sv
// l2_dual_port_arbiter
//   Shares the two L2 memory ports between NumReq host-side requesters.
//   Each request address is decoded to port 0, port 1 or a decode error.
//   Each port has its own round-robin arbiter. Responses come back in order
//   through a per-port ID FIFO. Decode errors are answered one cycle after
//   the grant.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i .. be_i        requester-side request channel (req/gnt)
//   gnt_o                request accepted this cycle
//   rvalid_o, rdata_o,   requester-side response channel
//   err_o
//   port_req_o ..        port-side request channel towards the two L2 ports
//   port_be_o, port_gnt_i
//   port_rvalid_i,       port-side in-order responses
//   port_rdata_i
module l2_dual_port_arbiter #(
  parameter int unsigned           NumReq    = 4,
  parameter int unsigned           AddrWidth = 64,
  parameter int unsigned           DataWidth = 64,
  parameter logic [AddrWidth-1:0]  Port0Base = AddrWidth'('h7800_0000),
  parameter logic [AddrWidth-1:0]  Port0Size = AddrWidth'('h0020_0000),
  parameter logic [AddrWidth-1:0]  Port1Base = Port0Base + Port0Size,
  parameter logic [AddrWidth-1:0]  Port1Size = Port0Size,
  parameter int unsigned           FifoDepth = 4,
  parameter int unsigned           MaxReqOut = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [NumReq-1:0][DataWidth-1:0]     rdata_o,
  output logic [NumReq-1:0]                    err_o,
  output logic [1:0]                           port_req_o,
  output logic [1:0][AddrWidth-1:0]            port_addr_o,
  output logic [1:0]                           port_we_o,
  output logic [1:0][DataWidth-1:0]            port_wdata_o,
  output logic [1:0][DataWidth/8-1:0]          port_be_o,
  input  logic [1:0]                           port_gnt_i,
  input  logic [1:0]                           port_rvalid_i,
  input  logic [1:0][DataWidth-1:0]            port_rdata_i
);

  localparam int unsigned IdW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned FCntW = $clog2(FifoDepth + 1);
  localparam int unsigned CntW  = $clog2(MaxReqOut + 1);

  localparam logic [FCntW-1:0]   FDepth  = FCntW'(FifoDepth);
  localparam logic [PtrW-1:0]    FLast   = PtrW'(FifoDepth - 1);
  localparam logic [CntW-1:0]    MaxOut  = CntW'(MaxReqOut);
  localparam logic [IdW-1:0]     IdLast  = IdW'(NumReq - 1);
  // Upper bounds carry one extra bit so the range compare cannot wrap.
  localparam logic [AddrWidth:0] Port0End = {1'b0, Port0Base} + {1'b0, Port0Size};
  localparam logic [AddrWidth:0] Port1End = {1'b0, Port1Base} + {1'b0, Port1Size};

  typedef enum logic [1:0] {DST_P0 = 2'd0, DST_P1 = 2'd1, DST_ERR = 2'd2} dst_e;

  function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] base, input int unsigned off);
    return IdW'((32'(base) + off) % NumReq);
  endfunction

  dst_e                  tgt      [NumReq];
  logic [CntW-1:0]       cnt_q    [NumReq];
  logic [CntW-1:0]       cnt_d    [NumReq];
  dst_e                  dst_q    [NumReq];
  dst_e                  dst_d    [NumReq];
  logic [NumReq-1:0]     err_pend_q, err_pend_d;
  logic [IdW-1:0]        ptr_q    [2];
  logic [IdW-1:0]        ptr_d    [2];
  logic [1:0]            lock_q, lock_d;
  logic [IdW-1:0]        lock_id_q[2];
  logic [IdW-1:0]        lock_id_d[2];
  logic [IdW-1:0]        fifo_q   [2][FifoDepth];
  logic [IdW-1:0]        fifo_d   [2][FifoDepth];
  logic [PtrW-1:0]       wptr_q   [2];
  logic [PtrW-1:0]       wptr_d   [2];
  logic [PtrW-1:0]       rptr_q   [2];
  logic [PtrW-1:0]       rptr_d   [2];
  logic [FCntW-1:0]      fcnt_q   [2];
  logic [FCntW-1:0]      fcnt_d   [2];

  logic [NumReq-1:0]            elig, err_gnt, gnt_int, rvalid_int, err_int;
  logic [1:0][NumReq-1:0]       cand;
  logic [NumReq-1:0][DataWidth-1:0] rdata_int;
  logic [IdW-1:0]               win  [2];
  logic [IdW-1:0]               head [2];
  logic [1:0]                   preq, hs, pop, fifo_ne;

  // Address decode and eligibility.
  always_comb begin
    elig    = '0;
    cand    = '0;
    err_gnt = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      if (({1'b0, addr_i[r]} >= {1'b0, Port0Base}) && ({1'b0, addr_i[r]} < Port0End)) begin
        tgt[r] = DST_P0;
      end else if (({1'b0, addr_i[r]} >= {1'b0, Port1Base}) && ({1'b0, addr_i[r]} < Port1End)) begin
        tgt[r] = DST_P1;
      end else begin
        tgt[r] = DST_ERR;
      end
      // A requester only talks to one destination at a time, so its
      // responses can never collide or reorder.
      elig[r]    = req_i[r] && (cnt_q[r] < MaxOut) && ((cnt_q[r] == '0) || (tgt[r] == dst_q[r]));
      cand[0][r] = elig[r] && (tgt[r] == DST_P0);
      cand[1][r] = elig[r] && (tgt[r] == DST_P1);
      err_gnt[r] = elig[r] && (tgt[r] == DST_ERR);
    end
  end

  // Per-port arbitration, FIFO bookkeeping and response routing.
  always_comb begin
    gnt_int    = err_gnt;
    rvalid_int = err_pend_q;
    err_int    = err_pend_q;
    rdata_int  = '0;
    fifo_d     = fifo_q;
    for (int unsigned p = 0; p < 2; p++) begin
      // Descending scan: the last hit is the one closest to the pointer.
      win[p] = ptr_q[p];
      for (int unsigned i = NumReq; i > 0; i--) begin
        if (cand[p][rr_idx(ptr_q[p], i - 1)]) win[p] = rr_idx(ptr_q[p], i - 1);
      end
      // A stalled request keeps its winner until the port accepts it.
      if (lock_q[p] && cand[p][lock_id_q[p]]) win[p] = lock_id_q[p];

      fifo_ne[p] = (fcnt_q[p] != '0);
      head[p]    = fifo_q[p][rptr_q[p]];
      pop[p]     = port_rvalid_i[p] && fifo_ne[p];
      // A pop this cycle frees a slot, so a full FIFO can still accept.
      preq[p]    = (|cand[p]) && !((fcnt_q[p] == FDepth) && !port_rvalid_i[p]);
      hs[p]      = preq[p] && port_gnt_i[p];

      port_addr_o[p]  = addr_i[win[p]];
      port_we_o[p]    = we_i[win[p]];
      port_wdata_o[p] = wdata_i[win[p]];
      port_be_o[p]    = be_i[win[p]];

      if (hs[p]) gnt_int[win[p]] = 1'b1;
      if (pop[p]) begin
        rvalid_int[head[p]] = 1'b1;
        rdata_int[head[p]]  = port_rdata_i[p];
      end

      ptr_d[p]     = hs[p] ? ((win[p] == IdLast) ? '0 : win[p] + 1'b1) : ptr_q[p];
      lock_d[p]    = preq[p] && !port_gnt_i[p];
      lock_id_d[p] = win[p];

      wptr_d[p] = wptr_q[p];
      rptr_d[p] = rptr_q[p];
      if (hs[p]) begin
        fifo_d[p][wptr_q[p]] = win[p];
        wptr_d[p] = (wptr_q[p] == FLast) ? '0 : wptr_q[p] + 1'b1;
      end
      if (pop[p]) rptr_d[p] = (rptr_q[p] == FLast) ? '0 : rptr_q[p] + 1'b1;
      case ({hs[p], pop[p]})
        2'b10:   fcnt_d[p] = fcnt_q[p] + 1'b1;
        2'b01:   fcnt_d[p] = fcnt_q[p] - 1'b1;
        default: fcnt_d[p] = fcnt_q[p];
      endcase
    end
  end

  // Per-requester outstanding counters and destinations.
  always_comb begin
    err_pend_d = err_gnt;
    for (int unsigned r = 0; r < NumReq; r++) begin
      cnt_d[r] = cnt_q[r];
      dst_d[r] = dst_q[r];
      if (gnt_int[r] && !rvalid_int[r]) cnt_d[r] = cnt_q[r] + 1'b1;
      if (!gnt_int[r] && rvalid_int[r]) cnt_d[r] = cnt_q[r] - 1'b1;
      if (gnt_int[r] && (cnt_q[r] == '0)) dst_d[r] = tgt[r];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_pend_q <= '0;
      lock_q     <= '0;
      for (int unsigned r = 0; r < NumReq; r++) begin
        cnt_q[r] <= '0;
        dst_q[r] <= DST_P0;
      end
      for (int unsigned p = 0; p < 2; p++) begin
        ptr_q[p]     <= '0;
        lock_id_q[p] <= '0;
        wptr_q[p]    <= '0;
        rptr_q[p]    <= '0;
        fcnt_q[p]    <= '0;
        for (int unsigned k = 0; k < FifoDepth; k++) fifo_q[p][k] <= '0;
      end
    end else begin
      err_pend_q <= err_pend_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      dst_q      <= dst_d;
      ptr_q      <= ptr_d;
      lock_id_q  <= lock_id_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fcnt_q     <= fcnt_d;
      fifo_q     <= fifo_d;
    end
  end

  // Valids and response data are forced low while reset is asserted.
  always_comb begin
    gnt_o      = rst_ni ? gnt_int    : '0;
    rvalid_o   = rst_ni ? rvalid_int : '0;
    err_o      = rst_ni ? err_int    : '0;
    rdata_o    = rst_ni ? rdata_int  : '0;
    port_req_o = rst_ni ? preq       : '0;
  end

  rvalid_without_txn: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (port_rvalid_i & ~fifo_ne) == 2'b00);

endmodule

// File: tb/tb_l2_dual_port_arbiter.sv
module tb_l2_dual_port_arbiter;
  localparam int NR = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_ni;
  logic [NR-1:0]           req_i, we_i, gnt_o, rvalid_o, err_o;
  logic [NR-1:0][AW-1:0]   addr_i;
  logic [NR-1:0][DW-1:0]   wdata_i, rdata_o;
  logic [NR-1:0][BW-1:0]   be_i;
  logic [1:0]              port_req_o, port_we_o, port_gnt_i, port_rvalid_i;
  logic [1:0][AW-1:0]      port_addr_o;
  logic [1:0][DW-1:0]      port_wdata_o, port_rdata_i;
  logic [1:0][BW-1:0]      port_be_o;

  l2_dual_port_arbiter #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW),
                         .FifoDepth(4), .MaxReqOut(3)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .port_req_o(port_req_o),
    .port_addr_o(port_addr_o), .port_we_o(port_we_o), .port_wdata_o(port_wdata_o),
    .port_be_o(port_be_o), .port_gnt_i(port_gnt_i), .port_rvalid_i(port_rvalid_i),
    .port_rdata_i(port_rdata_i));

  typedef struct { logic [AW-1:0] addr; int unsigned cyc; } pent_t;
  typedef struct { logic [DW-1:0] data; logic err; } exp_t;
  typedef struct {
    logic [NR-1:0]         req;
    logic [NR-1:0][AW-1:0] addr;
    logic [1:0]            pgnt;
    logic [NR-1:0]         exp_gnt;
    logic [1:0]            exp_preq;
  } vec_t;

  pent_t       pq    [2][$];
  exp_t        exp_q [NR][$];
  int unsigned lat   [2];
  logic [1:0]  resp_en;
  int unsigned cyc;
  int          n_chk, n_fail;
  vec_t        vecs  [8];

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 64'h7800_0040) return 64'hDEAD_BEEF;
    return {~a[31:0], a[31:0]};
  endfunction

  function automatic bit tb_is_err(input logic [AW-1:0] a);
    return !((a >= 64'h7800_0000) && (a < 64'h7840_0000));
  endfunction

  function automatic vec_t mkv(input logic [3:0] rq, input logic [AW-1:0] a0, a1, a2, a3,
                               input logic [1:0] pg, input logic [3:0] eg, input logic [1:0] ep);
    vec_t v;
    v.req = rq; v.addr = {a3, a2, a1, a0}; v.pgnt = pg; v.exp_gnt = eg; v.exp_preq = ep;
    return v;
  endfunction

  function automatic int outstanding();
    int n = pq[0].size() + pq[1].size();
    for (int r = 0; r < NR; r++) n += exp_q[r].size();
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Port model drives this cycle's response, then the outputs settle.
  task automatic settle();
    for (int p = 0; p < 2; p++) begin
      if (resp_en[p] && pq[p].size() > 0 && cyc >= pq[p][0].cyc + lat[p]) begin
        port_rvalid_i[p] = 1'b1;
        port_rdata_i[p]  = mem_fn(pq[p][0].addr);
      end else begin
        port_rvalid_i[p] = 1'b0;
        port_rdata_i[p]  = '0;
      end
    end
    #4;
  endtask

  // Scoreboard: pop on rvalid_o, push on gnt_o, track port handshakes.
  task automatic advance();
    exp_t e;
    for (int r = 0; r < NR; r++) begin
      if (rvalid_o[r]) begin
        if (exp_q[r].size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rvalid[%0d]: got rvalid 1 expected none outstanding", r);
        end else begin
          e = exp_q[r].pop_front();
          check($sformatf("rdata[%0d]", r), rdata_o[r], e.data);
          check($sformatf("err[%0d]", r), 64'(err_o[r]), 64'(e.err));
        end
      end
    end
    for (int r = 0; r < NR; r++) begin
      if (gnt_o[r]) begin
        e.err  = tb_is_err(addr_i[r]);
        e.data = e.err ? '0 : mem_fn(addr_i[r]);
        exp_q[r].push_back(e);
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (port_rvalid_i[p]) void'(pq[p].pop_front());
      if (port_req_o[p] && port_gnt_i[p]) pq[p].push_back('{port_addr_o[p], cyc});
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic drain();
    req_i = '0; port_gnt_i = '0; resp_en = 2'b11;
    for (int i = 0; i < 60 && outstanding() > 0; i++) cycle();
    if (outstanding() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", outstanding());
    end
  endtask

  task automatic do_reset();
    req_i = '0; port_gnt_i = '0; port_rvalid_i = '0; port_rdata_i = '0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) pq[p].delete();
    for (int r = 0; r < NR; r++) exp_q[r].delete();
    lat[0] = 2; lat[1] = 2; resp_en = 2'b11;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    lat[0] = 2; lat[1] = 2; resp_en = 2'b11;
    vecs[0] = mkv(4'b0101, 64'h7800_0000, 64'h0, 64'h7820_0000, 64'h0, 2'b11, 4'b0101, 2'b11);
    vecs[1] = mkv(4'b1010, 64'h0, 64'h781F_FFF8, 64'h0, 64'h783F_FFF8, 2'b11, 4'b1010, 2'b11);
    vecs[2] = mkv(4'b0001, 64'h7820_0000, 64'h0, 64'h0, 64'h0, 2'b00, 4'b0000, 2'b10);
    vecs[3] = mkv(4'b1010, 64'h0, 64'h77FF_FFF8, 64'h0, 64'h7840_0000, 2'b11, 4'b1010, 2'b00);
    vecs[4] = mkv(4'b1111, 64'h781F_FFFF, 64'h783F_FFFF, 64'h7840_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  2'b11, 4'b1111, 2'b11);
    vecs[5] = mkv(4'b0110, 64'h0, 64'h7800_0008, 64'h7820_0008, 64'h0, 2'b01, 4'b0010, 2'b11);
    vecs[6] = mkv(4'b0001, 64'h1_7800_0000, 64'h0, 64'h0, 64'h0, 2'b11, 4'b0001, 2'b00);
    vecs[7] = mkv(4'b1001, 64'h77FF_FFFF, 64'h0, 64'h0, 64'h7800_0000, 2'b10, 4'b0001, 2'b01);

    // Outputs while reset is held, with live inputs on every channel.
    rst_ni = 1'b0;
    we_i = 4'b0101;
    for (int r = 0; r < NR; r++) begin
      addr_i[r]  = 64'h7800_0000 + 64'(r * 8);
      wdata_i[r] = 64'hA5A5_0000_0000_0000 + 64'(r);
      be_i[r]    = 8'h0F;
    end
    req_i = '1; port_gnt_i = '1; port_rvalid_i = '1; port_rdata_i = '1;
    #3;
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_port_req", 64'(port_req_o), 64'h0);
    check("rst_rvalid", 64'(rvalid_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    for (int r = 0; r < NR; r++) check($sformatf("rst_rdata[%0d]", r), rdata_o[r], 64'h0);
    do_reset();

    // Single read through port 0.
    addr_i[0] = 64'h7800_0040; be_i[0] = 8'h3C; wdata_i[0] = 64'h1111_2222_3333_4444; we_i[0] = 1'b0;
    req_i = 4'b0001; port_gnt_i = 2'b01;
    settle();
    check("single_gnt", 64'(gnt_o), 64'h1);
    check("single_port_req", 64'(port_req_o), 64'h1);
    check("single_port_addr", port_addr_o[0], 64'h7800_0040);
    check("single_port_be", 64'(port_be_o[0]), 64'h3C);
    check("single_port_wdata", port_wdata_o[0], 64'h1111_2222_3333_4444);
    check("single_port_we", 64'(port_we_o[0]), 64'h0);
    advance();
    req_i = '0;
    settle(); check("single_rvalid_c1", 64'(rvalid_o), 64'h0); advance();
    settle();
    check("single_rvalid_c2", 64'(rvalid_o), 64'h1);
    check("single_rdata_c2", rdata_o[0], 64'hDEAD_BEEF);
    check("single_err_c2", 64'(err_o), 64'h0);
    check("single_p1_idle", 64'(port_req_o[1]), 64'h0);
    advance();
    drain();

    // Decode errors above and below the L2 window.
    begin
      logic [AW-1:0] bad [2];
      bad[0] = 64'h7840_0000; bad[1] = 64'h77FF_FFF8;
      for (int k = 0; k < 2; k++) begin
        addr_i[2] = bad[k]; req_i = 4'b0100; port_gnt_i = 2'b11;
        settle();
        check("decerr_gnt", 64'(gnt_o), 64'h4);
        check("decerr_no_port_req", 64'(port_req_o), 64'h0);
        advance();
        req_i = '0;
        settle();
        check("decerr_rvalid", 64'(rvalid_o), 64'h4);
        check("decerr_err", 64'(err_o), 64'h4);
        check("decerr_rdata", rdata_o[2], 64'h0);
        advance();
      end
    end
    drain();

    // Single-cycle table vectors, each from an idle state.
    foreach (vecs[k]) begin
      req_i = vecs[k].req; addr_i = vecs[k].addr; port_gnt_i = vecs[k].pgnt;
      settle();
      check($sformatf("vec%0d_gnt", k), 64'(gnt_o), 64'(vecs[k].exp_gnt));
      check($sformatf("vec%0d_port_req", k), 64'(port_req_o), 64'(vecs[k].exp_preq));
      advance();
      drain();
    end

    // Parallel ports: both issue together, pointers start at 0.
    do_reset();
    addr_i = {64'h783F_FFF8, 64'h7820_0000, 64'h781F_FFF8, 64'h7800_0000};
    req_i = 4'b1111; port_gnt_i = 2'b11;
    settle();
    check("par_gnt0", 64'(gnt_o), 64'h5);
    check("par_addr0_p0", port_addr_o[0], 64'h7800_0000);
    check("par_addr0_p1", port_addr_o[1], 64'h7820_0000);
    advance();
    settle();
    check("par_gnt1", 64'(gnt_o), 64'hA);
    check("par_addr1_p0", port_addr_o[0], 64'h781F_FFF8);
    check("par_addr1_p1", port_addr_o[1], 64'h783F_FFF8);
    advance();
    drain();

    // Round-robin on port 1.
    do_reset();
    for (int r = 0; r < NR; r++) addr_i[r] = 64'h7820_0000 + 64'(r * 8);
    req_i = '1; port_gnt_i = 2'b10;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("rr_gnt%0d", k), 64'(gnt_o), 64'(4'b0001 << (k % 4)));
      advance();
    end
    drain();

    // Full FIFO with a silent port 0, then a single response.
    do_reset();
    resp_en[0] = 1'b0;
    for (int r = 0; r < NR; r++) addr_i[r] = 64'h7800_0000 + 64'(r * 8);
    req_i = '1; port_gnt_i = 2'b01;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (k < 4) begin
        check($sformatf("full_gnt%0d", k), 64'(gnt_o), 64'(4'b0001 << k));
      end else begin
        check($sformatf("full_gnt%0d", k), 64'(gnt_o), 64'h0);
        check($sformatf("full_port_req%0d", k), 64'(port_req_o), 64'h0);
      end
      advance();
    end
    resp_en[0] = 1'b1;
    settle();
    check("full_pop_rvalid", 64'(rvalid_o), 64'h1);
    check("full_pop_gnt", 64'(gnt_o), 64'h1);
    check("full_pop_port_req", 64'(port_req_o), 64'h1);
    advance();
    drain();

    // Ordering: a port 1 request waits for the port 0 response.
    do_reset();
    lat[0] = 3;
    addr_i[0] = 64'h7800_0000; req_i = 4'b0001; port_gnt_i = 2'b11;
    settle(); check("ord_first_gnt", 64'(gnt_o), 64'h1); advance();
    addr_i[0] = 64'h7820_0000;
    for (int k = 1; k <= 3; k++) begin
      settle();
      check($sformatf("ord_hold_gnt%0d", k), 64'(gnt_o), 64'h0);
      check($sformatf("ord_hold_port_req%0d", k), 64'(port_req_o), 64'h0);
      if (k == 3) check("ord_resp_rvalid", 64'(rvalid_o), 64'h1);
      advance();
    end
    settle();
    check("ord_second_gnt", 64'(gnt_o), 64'h1);
    check("ord_second_port_req", 64'(port_req_o), 64'h2);
    advance();
    drain();

    // Reset in the middle of a burst.
    do_reset();
    resp_en[0] = 1'b0;
    addr_i[0] = 64'h7800_0000; addr_i[1] = 64'h7800_0008;
    req_i = 4'b0011; port_gnt_i = 2'b01;
    cycle(); cycle();
    rst_ni = 1'b0;
    #1;
    check("midrst_gnt", 64'(gnt_o), 64'h0);
    check("midrst_port_req", 64'(port_req_o), 64'h0);
    check("midrst_rvalid", 64'(rvalid_o), 64'h0);
    check("midrst_err", 64'(err_o), 64'h0);
    check("midrst_rdata0", rdata_o[0], 64'h0);
    do_reset();
    addr_i[0] = 64'h7820_0000; req_i = 4'b0001; port_gnt_i = 2'b11;
    settle();
    check("midrst_cnt_cleared_gnt", 64'(gnt_o), 64'h1);
    advance();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
